nibble_sub_serial: RTL and testbench
====================================

NIBBLE_SUB_SERIAL -- requirements
Module: nibble_sub_serial

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have in_valid  input  1  operand request valid.
REQ-004 SHALL have in_ready  output  1  block can accept operands.
REQ-005 SHALL have A  input  8  minuend.
REQ-006 SHALL have B  input  8  subtrahend.
REQ-007 SHALL have ctrl  input  1  mode: 0 = low-nibble subtract only, 1 = full 8-bit subtract.
REQ-008 SHALL have out_valid  output  1  result valid.
REQ-009 SHALL have out_ready  input  1  consumer accepts result.
REQ-010 SHALL have diff  output  8  difference.
REQ-011 SHALL have borrow  output  1  final borrow out (1 = A < B in the selected width).

Function
REQ-012 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL capture A, B and ctrl into internal registers on a cycle with in_valid=1 and in_ready=1, then go to LO.
REQ-015 SHALL ignore A, B, ctrl and in_valid changes outside the capture cycle.
REQ-016 In LO, SHALL compute A[3:0]-B[3:0] with borrow-in 0, store the 4-bit result in diff[3:0] and the borrow in an internal register.
REQ-017 From LO, SHALL go to HI if captured ctrl=1, otherwise to DONE.
REQ-018 In HI, SHALL compute A[7:4]-B[7:4]-stored_borrow and store the result in diff[7:4] and borrow.
REQ-019 With ctrl=0, SHALL drive diff[7:4]=4'h0 and borrow = the low-nibble borrow.
REQ-020 Latency from capture to out_valid SHALL be 2 cycles for ctrl=0 and 3 cycles for ctrl=1.
REQ-021 SHALL assert out_valid only in DONE, and hold diff and borrow stable while out_valid=1 and out_ready=0.
REQ-022 In DONE with out_ready=1, SHALL return to IDLE on the next edge; in_ready rises one cycle after the handshake.
REQ-023 Arithmetic SHALL be modulo 2^4 per nibble; borrow SHALL propagate only from LO to HI.
REQ-024 An out_ready pulse while out_valid=0 SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, the FSM SHALL go to IDLE, and diff, borrow, the internal borrow and out_valid SHALL clear to 0.
REQ-026 After reset, in_ready SHALL be 1.
REQ-027 Reset SHALL take priority over any handshake in the same cycle and SHALL abort an in-flight operation with no result produced.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (2-bit encoding) and the constants NIB_W=4 and DATA_W=8.
REQ-029 SHALL instantiate one combinational sub-module, nibble_sub4 (4-bit a, b, bin -> 4-bit d, bout), reused for both nibble phases.

Verification
REQ-030 A=8'h24, B=8'h81, ctrl=1, out_ready=1 -> diff=8'hA3, borrow=1, out_valid 3 cycles after capture.
REQ-031 ctrl=0: A=8'h09, B=8'h63 -> diff=8'h06, borrow=0; A=8'h01, B=8'h0d -> diff=8'h04, borrow=1; each after 2 cycles.
REQ-032 Inter-nibble borrow: A=8'h12, B=8'h8f, ctrl=1 -> diff=8'h83, borrow=1; A=8'hed, B=8'h8c -> diff=8'h61, borrow=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff, borrow and out_valid stay stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 Reset mid-operation: rst=1 in HI -> next cycle IDLE, out_valid=0, diff=0, in_ready=1; no stale result ever appears.
REQ-035 Operand change during LO/HI (A, B set to 8'hFF) -> result matches the captured operands.

Source files
------------

// File: rtl/nibble_sub_serial_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Holds the FSM state encoding and the nibble/data width constants.
package nibble_sub_serial_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/nibble_sub_serial_sub4.sv
// 4-bit subtractor with borrow-in and borrow-out, purely combinational.
// Ports:
//   a, b  - nibble operands (a - b)
//   bin   - borrow in
//   d     - 4-bit difference, modulo 2^4
//   bout  - borrow out (1 when a < b + bin)
module nibble_sub4
    import nibble_sub_serial_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W:0] full;

    // One extra bit catches the wrap-around; it is the borrow.
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
        d    = full[NIB_W-1:0];
        bout = full[NIB_W];
    end

endmodule

// File: rtl/nibble_sub_serial.sv
// Nibble-serial 8-bit subtractor with valid/ready handshakes on both sides.
// Operands are captured in IDLE, the low nibble is subtracted in LO, the high
// nibble (with the low-nibble borrow) in HI when ctrl=1, and the result is
// presented in DONE until the consumer accepts it.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready only in IDLE)
//   A, B, ctrl          - minuend, subtrahend, mode (0 = low nibble, 1 = full)
//   out_valid, out_ready- result handshake (out_valid only in DONE)
//   diff, borrow        - difference and final borrow
module nibble_sub_serial
    import nibble_sub_serial_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic              ctrl_q;
    logic [DATA_W-1:0] diff_q;
    logic              borrow_q;
    logic              bint_q;

    logic [NIB_W-1:0]  sub_a, sub_b, sub_d;
    logic              sub_bin, sub_bout;

    // Single subtractor shared by both phases; HI selects the upper nibble.
    always_comb begin
        if (state_q == StHi) begin
            sub_a   = a_q[DATA_W-1:NIB_W];
            sub_b   = b_q[DATA_W-1:NIB_W];
            sub_bin = bint_q;
        end else begin
            sub_a   = a_q[NIB_W-1:0];
            sub_b   = b_q[NIB_W-1:0];
            sub_bin = 1'b0;
        end
    end

    nibble_sub4 u_sub4 (
        .a    (sub_a),
        .b    (sub_b),
        .bin  (sub_bin),
        .d    (sub_d),
        .bout (sub_bout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StLo;
            StLo:    state_d = ctrl_q ? StHi : StDone;
            StHi:    state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bint_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        ctrl_q <= ctrl;
                    end
                end
                StLo: begin
                    diff_q[NIB_W-1:0] <= sub_d;
                    bint_q            <= sub_bout;
                    // Low-nibble mode finishes here: upper nibble forced to zero.
                    if (!ctrl_q) begin
                        diff_q[DATA_W-1:NIB_W] <= '0;
                        borrow_q               <= sub_bout;
                    end
                end
                StHi: begin
                    diff_q[DATA_W-1:NIB_W] <= sub_d;
                    borrow_q               <= sub_bout;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_nibble_sub_serial.sv
module tb_nibble_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic       ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    // Present operands for one capture cycle, return one cycle after capture (in LO).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        A = a; B = b; ctrl = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from capture to out_valid; capped at 20 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (diff !== 8'h00 || borrow !== 1'b0) begin
            n_fail++; $display("FAIL reset_result got %h/%b want 00/0", diff, borrow);
        end
    endtask

    task automatic test_full_sub();
        int lat;
        out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_in_ready got %b want 1", in_ready);
        end
        start_op(8'h24, 8'h81, 1'b1);
        wait_done(lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL full_latency got %0d want 3", lat);
        end
        n_checks++;
        if (diff !== 8'hA3 || borrow !== 1'b1) begin
            n_fail++; $display("FAIL full_result got %h/%b want a3/1", diff, borrow);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_return got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_low_sub();
        logic [7:0] va [2] = '{8'h09, 8'h01};
        logic [7:0] vb [2] = '{8'h63, 8'h0d};
        logic [7:0] vd [2] = '{8'h06, 8'h04};
        logic       vbo[2] = '{1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_done(lat);
            n_checks++;
            if (lat !== 2) begin
                n_fail++; $display("FAIL low_latency[%0d] got %0d want 2", i, lat);
            end
            n_checks++;
            if (diff !== vd[i] || borrow !== vbo[i]) begin
                n_fail++;
                $display("FAIL low_result[%0d] got %h/%b want %h/%b", i, diff, borrow, vd[i], vbo[i]);
            end
            handshake();
        end
    endtask

    task automatic test_inter_borrow();
        logic [7:0] va [2] = '{8'h12, 8'hed};
        logic [7:0] vb [2] = '{8'h8f, 8'h8c};
        logic [7:0] vd [2] = '{8'h83, 8'h61};
        logic       vbo[2] = '{1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], 1'b1);
            wait_done(lat);
            n_checks++;
            if (lat !== 3 || diff !== vd[i] || borrow !== vbo[i]) begin
                n_fail++;
                $display("FAIL inter_borrow[%0d] got lat=%0d %h/%b want lat=3 %h/%b",
                         i, lat, diff, borrow, vd[i], vbo[i]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(8'h09, 8'h63, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'h06 || borrow !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d] got vld=%b rdy=%b %h/%b want 1/0 06/0",
                         i, out_valid, in_ready, diff, borrow);
            end
            @(posedge clk); #1;
        end
        handshake();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_release got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        start_op(8'h24, 8'h81, 1'b1);
        @(posedge clk); #1;               // now in HI
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got rdy=%b vld=%b %h/%b want 1/0 00/0",
                     in_ready, out_valid, diff, borrow);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_stale got out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        start_op(8'h12, 8'h8f, 1'b1);
        A = 8'hFF; B = 8'hFF; ctrl = 1'b0; in_valid = 1'b1;
        wait_done(lat);
        in_valid = 1'b0;
        n_checks++;
        if (lat !== 3 || diff !== 8'h83 || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL operand_change got lat=%0d %h/%b want lat=3 83/1", lat, diff, borrow);
        end
        handshake();
    endtask

    task automatic test_spurious_ready();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL spurious_ready got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; ctrl = 1'b0; out_ready = 1'b0;
        test_reset();
        test_full_sub();
        test_low_sub();
        test_inter_borrow();
        test_backpressure();
        test_reset_mid();
        test_operand_change();
        test_spurious_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
